// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - framed LSB-first bit-serial transmitter with clock enable
// Optional even parity bit between data and stop: define SERIAL_TX_PARITY_EN.
module serial_tx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int DIV_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef SERIAL_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [2:0]           state, state_n;
  logic [DIV_W-1:0]     div, div_n;
  logic [IDX_W-1:0]     bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 tx_n, busy_n, done_n;
  logic                 bit_end;
`ifdef SERIAL_TX_PARITY_EN
  logic                 parity_q, parity_n;
`endif

  assign bit_end = (div == DIV_LAST);

  always_comb begin
    state_n   = state;
    div_n     = div;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    tx_n      = tx;
    busy_n    = busy;
    done_n    = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    parity_n  = parity_q;
`endif
    // With enable low every register except the one-shot done holds.
    if (enable) begin
      case (state)
        ST_IDLE: begin
          // The done cycle is spent in IDLE, so a start on it is refused.
          if (start && !done) begin
            state_n   = ST_START;
            div_n     = '0;
            bit_idx_n = '0;
            shift_n   = data_in;
            tx_n      = 1'b0;
            busy_n    = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            parity_n  = ^data_in;
`endif
          end
        end
        ST_START: begin
          if (bit_end) begin
            div_n   = '0;
            state_n = ST_DATA;
            tx_n    = shift[0];
          end else begin
            div_n = div + DIV_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            div_n = '0;
            if (bit_idx == IDX_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
              state_n = ST_PARITY;
              tx_n    = parity_q;
`else
              state_n = ST_STOP;
              tx_n    = 1'b1;
`endif
            end else begin
              // tx is registered, so present the bit that the shift exposes next.
              shift_n   = shift >> 1;
              bit_idx_n = bit_idx + IDX_W'(1);
              tx_n      = shift[1];
            end
          end else begin
            div_n = div + DIV_W'(1);
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            div_n   = '0;
            state_n = ST_STOP;
            tx_n    = 1'b1;
          end else begin
            div_n = div + DIV_W'(1);
          end
        end
`endif
        ST_STOP: begin
          if (bit_end) begin
            div_n   = '0;
            state_n = ST_IDLE;
            tx_n    = 1'b1;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            div_n = div + DIV_W'(1);
          end
        end
        default: begin
          state_n = ST_IDLE;
          div_n   = '0;
          tx_n    = 1'b1;
          busy_n  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      div     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      div     <= div_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      tx      <= tx_n;
      busy    <= busy_n;
      done    <= done_n;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= parity_n;
`endif
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// tb/tb_serial_tx.sv - directed self-checking bench for serial_tx
// Expected waveforms come from constant bit tables built in the bench.
module tb_serial_tx;

  localparam int CPB = 8;
  localparam int DB  = 8;
`ifdef SERIAL_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FLEN = (DB + 2 + PAR) * CPB;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          start;
  logic [DB-1:0] data_in;
  logic          tx;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  serial_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .data_in(data_in), .tx(tx), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One frame: optional enable stall of l cycles from interval s, optional
  // extra start (with 0xFF) at interval rej_at while the frame is in flight.
  task automatic frame(input string tag, input logic [DB-1:0] d, input logic p,
                       input int s, input int l, input int rej_at);
    logic lv[$];
    logic ex[$];
    int nbusy, ndone, done_at, txerr, flen;
    lv.delete();
    ex.delete();
    repeat (CPB) lv.push_back(1'b0);
    for (int i = 0; i < DB; i++) repeat (CPB) lv.push_back(d[i]);
    if (PAR == 1) repeat (CPB) lv.push_back(p);
    repeat (CPB) lv.push_back(1'b1);
    for (int i = 0; i < lv.size(); i++) begin
      ex.push_back(lv[i]);
      if (i == s) repeat (l) ex.push_back(lv[i]);
    end
    flen = ex.size();
    nbusy = 0; ndone = 0; done_at = -1; txerr = 0;
    data_in = d; start = 1'b1; enable = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < flen + 4; c++) begin
      if (busy === 1'b1) nbusy++;
      if (done === 1'b1) begin ndone++; done_at = c; end
      if (c < flen && tx !== ex[c]) txerr++;
      if (c >= flen && tx !== 1'b1) txerr++;
      enable = !(s >= 0 && c >= s && c < s + l);
      start = (c == rej_at);
      if (c == rej_at) data_in = 8'hFF;
      step();
    end
    start = 1'b0;
    enable = 1'b1;
    chk({tag, "_tx_bits"}, txerr, 0);
    chk({tag, "_busy_len"}, nbusy, flen);
    chk({tag, "_done_at"}, done_at, flen);
    chk({tag, "_done_cnt"}, ndone, 1);
  endtask

  logic got [0:259];
  int d1, s2, gaperr, ndone, nbusy;
  logic [DB-1:0] dec1, dec2;

  initial begin
    reset = 1'b1; enable = 1'b0; start = 1'b0; data_in = '0;
    #3;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    step();
    step();
    reset = 1'b0;
    step();

    // start with enable low is never accepted
    enable = 1'b0; start = 1'b1; data_in = 8'h5A;
    repeat (5) step();
    chk("noen_busy", busy, 0);
    chk("noen_tx", tx, 1);
    start = 1'b0; enable = 1'b1;
    step();

    frame("basic_a5", 8'hA5, 1'b0, -1, 0, -1);
    frame("reject_3c", 8'h3C, 1'b0, -1, 0, 20);
    frame("stall_01", 8'h01, 1'b1, 10, 5, -1);
`ifdef SERIAL_TX_PARITY_EN
    frame("par_07", 8'h07, 1'b1, -1, 0, -1);
    frame("par_03", 8'h03, 1'b0, -1, 0, -1);
`endif

    // async reset during data bit 3 of 0xA5 (bit 3 is 0)
    data_in = 8'hA5; start = 1'b1; enable = 1'b1;
    step();
    start = 1'b0;
    repeat (35) step();
    chk("mid_pre_tx", tx, 0);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    #2 reset = 1'b0;
    ndone = 0; nbusy = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (done === 1'b1) ndone++;
      if (busy === 1'b1) nbusy++;
    end
    chk("mid_no_done", ndone, 0);
    chk("mid_no_busy", nbusy, 0);

    // back-to-back with start held high
    data_in = 8'h55; start = 1'b1; enable = 1'b1;
    step();
    data_in = 8'hAA;
    d1 = -1; s2 = -1; gaperr = 0;
    for (int c = 0; c < 260; c++) begin
      got[c] = tx;
      if (d1 < 0 && done === 1'b1) d1 = c;
      if (d1 >= 0 && s2 < 0 && c > d1 && tx === 1'b0) s2 = c;
      if (d1 >= 0 && s2 < 0 && tx !== 1'b1) gaperr++;
      step();
    end
    start = 1'b0;
    if (s2 < 0 || s2 > 180) s2 = 0;
    for (int i = 0; i < DB; i++) begin
      dec1[i] = got[CPB + CPB * i + CPB / 2];
      dec2[i] = got[s2 + CPB + CPB * i + CPB / 2];
    end
    chk("b2b_first_done", d1, FLEN);
    chk("b2b_gap_ge1", int'(s2 - d1 >= 1), 1);
    chk("b2b_gap_tx", gaperr, 0);
    chk("b2b_data1", int'(dec1), 8'h55);
    chk("b2b_data2", int'(dec2), 8'hAA);
    repeat (120) step();
    chk("b2b_idle_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
